// File: rtl/nn_argmax_unit.sv
// rtl/nn_argmax_unit.sv - sequential argmax/runner-up/margin scan over ten class scores with HEX/LEDR drive
module nn_argmax_unit #(
  parameter int N_CLASSES = 10,
  parameter int W         = 16
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic         start,
  input  logic [W-1:0] Probability [N_CLASSES-1:0],
  output logic         busy,
  output logic         done,
  output logic         valid,
  output logic [3:0]   digit,
  output logic [3:0]   runner_up,
  output logic [W-1:0] max_score,
  output logic [W-1:0] margin,
  output logic [7:0]   HEX,
  output logic [9:0]   LEDR
);

  typedef enum logic [1:0] {IDLE, SCAN, FINISH} state_t;

  state_t              state_q, state_d;
  logic [3:0]          idx_q, idx_d;
  logic [W-1:0]        snap_q [N_CLASSES-1:0];
  logic [3:0]          best_idx_q, best_idx_d, sec_idx_q, sec_idx_d;
  logic signed [W-1:0] best_val_q, best_val_d, sec_val_q, sec_val_d;
  logic signed [W-1:0] cur_val;
  logic signed [W:0]   diff;
  logic [W-1:0]        margin_sat;
  logic                accept;

  logic         busy_q, done_q, valid_q;
  logic [3:0]   digit_q, runner_q;
  logic [W-1:0] max_q, margin_q;
  logic [7:0]   hex_q;
  logic [9:0]   ledr_q;

  // Active-low seven-segment pattern, DP kept dark
  function automatic logic [7:0] hex_code(input logic [3:0] d);
    case (d)
      4'd0:    return 8'hC0;
      4'd1:    return 8'hF9;
      4'd2:    return 8'hA4;
      4'd3:    return 8'hB0;
      4'd4:    return 8'h99;
      4'd5:    return 8'h92;
      4'd6:    return 8'h82;
      4'd7:    return 8'hF8;
      4'd8:    return 8'h80;
      4'd9:    return 8'h90;
      default: return 8'hFF;
    endcase
  endfunction

  assign accept  = (state_q == IDLE) && start;
  assign cur_val = $signed(snap_q[idx_q]);

  // Next state, scan index and best/second tracking; ties keep the lower index
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    best_idx_d = best_idx_q;
    best_val_d = best_val_q;
    sec_idx_d  = sec_idx_q;
    sec_val_d  = sec_val_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = SCAN;
          idx_d   = 4'd0;
        end
      end
      SCAN: begin
        if (idx_q == 4'd0) begin
          best_idx_d = 4'd0;
          best_val_d = cur_val;
          sec_idx_d  = 4'd0;
          sec_val_d  = cur_val;
        end else if (idx_q == 4'd1) begin
          if (cur_val > best_val_q) begin
            best_idx_d = idx_q;
            best_val_d = cur_val;
            sec_idx_d  = best_idx_q;
            sec_val_d  = best_val_q;
          end else begin
            sec_idx_d = idx_q;
            sec_val_d = cur_val;
          end
        end else if (cur_val > best_val_q) begin
          best_idx_d = idx_q;
          best_val_d = cur_val;
          sec_idx_d  = best_idx_q;
          sec_val_d  = best_val_q;
        end else if (cur_val > sec_val_q) begin
          sec_idx_d = idx_q;
          sec_val_d = cur_val;
        end
        if (idx_q == 4'(N_CLASSES - 1)) begin
          state_d = FINISH;
        end else begin
          idx_d = idx_q + 4'd1;
        end
      end
      FINISH: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Best minus second in one extra bit, clamped to the unsigned output range
  always_comb begin
    diff = {best_val_q[W-1], best_val_q} - {sec_val_q[W-1], sec_val_q};
    if (diff > $signed({1'b0, {W{1'b1}}})) begin
      margin_sat = {W{1'b1}};
    end else begin
      margin_sat = diff[W-1:0];
    end
  end

  // FSM and scan-tracking registers
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q    <= IDLE;
      idx_q      <= 4'd0;
      best_idx_q <= 4'd0;
      best_val_q <= '0;
      sec_idx_q  <= 4'd0;
      sec_val_q  <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      best_idx_q <= best_idx_d;
      best_val_q <= best_val_d;
      sec_idx_q  <= sec_idx_d;
      sec_val_q  <= sec_val_d;
    end
  end

  // Score snapshot taken on the accepted start so later input changes are ignored
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < N_CLASSES; i++) snap_q[i] <= '0;
    end else if (accept) begin
      for (int i = 0; i < N_CLASSES; i++) snap_q[i] <= Probability[i];
    end
  end

  // Registered status and result outputs; results only change in FINISH
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      valid_q  <= 1'b0;
      digit_q  <= 4'd0;
      runner_q <= 4'd0;
      max_q    <= '0;
      margin_q <= '0;
      hex_q    <= 8'hFF;
      ledr_q   <= 10'd0;
    end else begin
      busy_q <= accept || (state_q == SCAN) || (state_q == FINISH);
      done_q <= (state_q == FINISH);
      if (state_q == FINISH) begin
        valid_q  <= 1'b1;
        digit_q  <= best_idx_q;
        runner_q <= sec_idx_q;
        max_q    <= best_val_q;
        margin_q <= margin_sat;
        hex_q    <= hex_code(best_idx_q);
        ledr_q   <= 10'd1 << best_idx_q;
      end
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign valid     = valid_q;
  assign digit     = digit_q;
  assign runner_up = runner_q;
  assign max_score = max_q;
  assign margin    = margin_q;
  assign HEX       = hex_q;
  assign LEDR      = ledr_q;

endmodule

// File: tb/tb_nn_argmax_unit.sv
// tb/tb_nn_argmax_unit.sv - table-driven and randomized self-checking bench for nn_argmax_unit
module tb_nn_argmax_unit;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        start;
  logic [15:0] prob [9:0];
  logic        busy, done, valid;
  logic [3:0]  digit, runner_up;
  logic [15:0] max_score, margin;
  logic [7:0]  HEX;
  logic [9:0]  LEDR;

  int checks = 0;
  int passed = 0;

  typedef struct packed {
    logic [9:0][15:0] sc;
    logic [3:0]       d;
    logic [3:0]       r;
    logic [15:0]      mx;
    logic [15:0]      mg;
  } vec_t;

  vec_t vecs [$];

  nn_argmax_unit #(.N_CLASSES(10), .W(16)) dut (
    .Clk(Clk), .Reset(Reset), .start(start), .Probability(prob),
    .busy(busy), .done(done), .valid(valid), .digit(digit), .runner_up(runner_up),
    .max_score(max_score), .margin(margin), .HEX(HEX), .LEDR(LEDR)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [7:0] ref_hex(input logic [3:0] d);
    logic [7:0] tbl [10];
    tbl = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};
    return tbl[d];
  endfunction

  // Winner = lowest index holding the maximum; runner-up = same rule over the rest
  function automatic vec_t ref_model(input logic [9:0][15:0] sc);
    vec_t v;
    int b, r, m;
    b = 0;
    for (int i = 1; i < 10; i++) if ($signed(sc[i]) > $signed(sc[b])) b = i;
    r = (b == 0) ? 1 : 0;
    for (int i = 0; i < 10; i++)
      if (i != b && $signed(sc[i]) > $signed(sc[r])) r = i;
    m = int'($signed(sc[b])) - int'($signed(sc[r]));
    if (m > 65535) m = 65535;
    v.sc = sc;
    v.d  = 4'(b);
    v.r  = 4'(r);
    v.mx = sc[b];
    v.mg = 16'(m);
    return v;
  endfunction

  task automatic drive(input logic [9:0][15:0] sc);
    for (int i = 0; i < 10; i++) prob[i] = sc[i];
  endtask

  // Pulse start and count edges until done; returns 20 if it never arrives
  task automatic launch_and_wait(output int lat);
    start = 1'b1;
    @(posedge Clk); #1;
    start = 1'b0;
    chk("busy_after_start", busy, 1);
    lat = 0;
    while (lat < 20) begin
      @(posedge Clk); #1;
      lat++;
      if (done) break;
    end
  endtask

  task automatic check_result(input string tag, input vec_t v);
    chk({tag, "_digit"}, digit, v.d);
    chk({tag, "_runner"}, runner_up, v.r);
    chk({tag, "_max"}, max_score, v.mx);
    chk({tag, "_margin"}, margin, v.mg);
    chk({tag, "_hex"}, HEX, ref_hex(v.d));
    chk({tag, "_ledr"}, LEDR, 10'd1 << v.d);
    chk({tag, "_valid"}, valid, 1);
  endtask

  initial begin
    vec_t v;
    logic [9:0][15:0] sc;
    int lat, ndone, first;

    Reset = 1'b1;
    start = 1'b0;
    for (int i = 0; i < 10; i++) prob[i] = 16'd0;

    for (int i = 0; i < 10; i++) sc[i] = 16'(100 * (i + 1));
    vecs.push_back('{sc: sc, d: 4'd9, r: 4'd8, mx: 16'd1000, mg: 16'd100});
    for (int i = 0; i < 10; i++) sc[i] = 16'hFFFB;
    sc[3] = 16'd7; sc[6] = 16'd7;
    vecs.push_back('{sc: sc, d: 4'd3, r: 4'd6, mx: 16'd7, mg: 16'd0});
    for (int i = 0; i < 10; i++) sc[i] = 16'h8000;
    sc[2] = 16'h7FFF;
    vecs.push_back('{sc: sc, d: 4'd2, r: 4'd0, mx: 16'h7FFF, mg: 16'hFFFF});
    for (int i = 0; i < 10; i++) sc[i] = 16'd50;
    vecs.push_back('{sc: sc, d: 4'd0, r: 4'd1, mx: 16'd50, mg: 16'd0});
    for (int i = 0; i < 10; i++) sc[i] = 16'(10 - i);
    vecs.push_back('{sc: sc, d: 4'd0, r: 4'd1, mx: 16'd10, mg: 16'd1});
    for (int n = 0; n < 10; n++) begin
      for (int i = 0; i < 10; i++)
        sc[i] = (n % 2 == 0) ? 16'($urandom) : 16'($urandom_range(0, 3)) - 16'd1;
      vecs.push_back(ref_model(sc));
    end

    repeat (3) @(posedge Clk);
    #1;
    Reset = 1'b0;
    ndone = 0;
    for (int c = 0; c < 30; c++) begin
      @(posedge Clk); #1;
      if (done) ndone++;
    end
    chk("idle_done_count", ndone, 0);
    chk("reset_hex", HEX, 8'hFF);
    chk("reset_ledr", LEDR, 0);
    chk("reset_valid", valid, 0);
    chk("reset_busy", busy, 0);
    chk("reset_digit", digit, 0);
    chk("reset_margin", margin, 0);

    foreach (vecs[k]) begin
      drive(vecs[k].sc);
      launch_and_wait(lat);
      chk($sformatf("vec%0d_latency", k), lat, 11);
      check_result($sformatf("vec%0d", k), vecs[k]);
      @(posedge Clk); #1;
      chk($sformatf("vec%0d_done_low", k), done, 0);
      chk($sformatf("vec%0d_busy_low", k), busy, 0);
    end

    for (int i = 0; i < 10; i++) sc[i] = 16'h8000;
    sc[2] = 16'h7FFF;
    v = ref_model(sc);
    drive(sc);
    start = 1'b1;
    @(posedge Clk); #1;
    start = 1'b0;
    for (int i = 0; i < 10; i++) prob[i] = 16'(i);
    prob[7] = 16'h7FFF;
    lat = 0;
    while (lat < 20) begin
      @(posedge Clk); #1;
      lat++;
      if (done) break;
    end
    chk("snap_latency", lat, 11);
    check_result("snap", v);

    @(posedge Clk); #1;
    for (int i = 0; i < 10; i++) sc[i] = 16'(i * 3);
    sc[4] = 16'd500;
    v = ref_model(sc);
    drive(sc);
    start = 1'b1;
    @(posedge Clk); #1;
    start = 1'b0;
    ndone = 0;
    first = 0;
    for (int c = 1; c <= 30; c++) begin
      if (c == 5) start = 1'b1;
      @(posedge Clk); #1;
      start = 1'b0;
      if (done) begin
        ndone++;
        if (first == 0) first = c;
      end
    end
    chk("busy_reject_done_count", ndone, 1);
    chk("busy_reject_first_done", first, 11);
    check_result("busy_reject", v);

    for (int i = 0; i < 10; i++) sc[i] = 16'(1000 - 7 * i);
    v = ref_model(sc);
    drive(sc);
    launch_and_wait(lat);
    chk("b2b_first_latency", lat, 11);
    for (int i = 0; i < 10; i++) sc[i] = 16'(i);
    sc[8] = 16'd77;
    v = ref_model(sc);
    drive(sc);
    start = 1'b1;
    lat = 0;
    while (lat < 20) begin
      @(posedge Clk); #1;
      start = 1'b0;
      lat++;
      if (done) break;
    end
    chk("b2b_second_gap", lat, 12);
    check_result("b2b", v);

    @(posedge Clk); #1;
    start = 1'b1;
    @(posedge Clk); #1;
    start = 1'b0;
    repeat (3) @(posedge Clk);
    #1;
    Reset = 1'b1;
    #1;
    chk("midreset_busy", busy, 0);
    chk("midreset_valid", valid, 0);
    chk("midreset_hex", HEX, 8'hFF);
    chk("midreset_ledr", LEDR, 0);
    @(posedge Clk); #1;
    Reset = 1'b0;
    ndone = 0;
    for (int c = 0; c < 20; c++) begin
      @(posedge Clk); #1;
      if (done || busy) ndone++;
    end
    chk("midreset_no_done", ndone, 0);
    chk("midreset_digit", digit, 0);
    chk("midreset_runner", runner_up, 0);
    chk("midreset_max", max_score, 0);
    chk("midreset_margin", margin, 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
